// File: rtl/loudness_level_tracker_pkg.sv
// Shared types and helpers for the loudness level tracker: level encoding,
// default loudness width and a saturating subtractor used by the hysteresis.
package loudness_pkg;

  localparam int LOUDNESS_W = 43;

  typedef enum logic [1:0] {
    QUIET     = 2'd0,
    MODERATE  = 2'd1,
    LOUD      = 2'd2,
    VERY_LOUD = 2'd3
  } level_t;

  // a - b, clamped at zero instead of wrapping.
  function automatic logic [LOUDNESS_W-1:0] sat_sub(input logic [LOUDNESS_W-1:0] a,
                                                    input logic [LOUDNESS_W-1:0] b);
    return (a > b) ? a - b : '0;
  endfunction

endpackage

// File: rtl/loudness_level_tracker_if.sv
// Bundle of loudness samples, thresholds and level/alarm results between the
// loudness accumulator (master) and the level tracker (slave).
interface loudness_level_tracker_if
  import loudness_pkg::*;
#(
  parameter int LW = LOUDNESS_W
);
  logic [LW-1:0] loudness;
  logic          loudness_valid;
  logic [LW-1:0] th1;
  logic [LW-1:0] th2;
  logic [LW-1:0] th3;
  logic [LW-1:0] avg_loudness;
  level_t        level;
  logic          level_valid;
  logic          alarm;

  modport master (
    output loudness, loudness_valid, th1, th2, th3,
    input  avg_loudness, level, level_valid, alarm
  );

  modport slave (
    input  loudness, loudness_valid, th1, th2, th3,
    output avg_loudness, level, level_valid, alarm
  );
endinterface

// File: rtl/loudness_level_tracker_moving_avg.sv
// Moving average over the last 2^AVG_LOG2 loudness windows, kept as a ring
// buffer plus a running sum so each update costs one add and one subtract.
module loudness_moving_avg #(
  parameter int LW       = 43,
  parameter int AVG_LOG2 = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [LW-1:0] in_data_i,
  input  logic          in_valid_i,
  output logic [LW-1:0] avg_o,
  output logic          avg_valid_o
);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = LW + AVG_LOG2;

  logic [LW-1:0]       ring_q [DEPTH];
  logic [AVG_LOG2-1:0] wr_ptr_q;
  logic [SW-1:0]       sum_q;
  logic [SW-1:0]       sum_d;
  logic                avg_valid_q;

  // The entry under the write pointer is always the oldest sample.
  assign sum_d = sum_q + SW'(in_data_i) - SW'(ring_q[wr_ptr_q]);

  // NOTE: the ring is reset like any other register because empty slots must
  // read as zero for the running sum to ramp up correctly after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
      wr_ptr_q    <= '0;
      sum_q       <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      avg_valid_q <= in_valid_i;
      if (in_valid_i) begin
        ring_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q         <= wr_ptr_q + AVG_LOG2'(1);
        sum_q            <= sum_d;
      end
    end
  end

  assign avg_o       = sum_q[SW-1:AVG_LOG2];
  assign avg_valid_o = avg_valid_q;

endmodule

// File: rtl/loudness_level_tracker.sv
// Classifies the smoothed loudness into four levels with downward hysteresis
// and raises an alarm after HOLD consecutive VERY_LOUD updates.
module loudness_level_tracker
  import loudness_pkg::*;
#(
  parameter int LW       = LOUDNESS_W,
  parameter int AVG_LOG2 = 2,
  parameter int HYST     = 4096,
  parameter int HOLD     = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  loudness_level_tracker_if.slave  bus
);
  localparam int            CW     = $clog2(HOLD + 1);
  localparam logic [CW-1:0] HOLD_C = CW'(HOLD);

  logic [LW-1:0] avg;
  logic          avg_valid;
  logic [LW-1:0] th_cur;
  level_t        raw;
  level_t        level_d;
  level_t        level_q;
  logic [CW-1:0] count_d;
  logic [CW-1:0] count_q;
  logic          alarm_q;
  logic          level_valid_q;

  loudness_moving_avg #(
    .LW       (LW),
    .AVG_LOG2 (AVG_LOG2)
  ) u_moving_avg (
    .clk         (clk),
    .rst_n       (reset),
    .in_data_i   (bus.loudness),
    .in_valid_i  (bus.loudness_valid),
    .avg_o       (avg),
    .avg_valid_o (avg_valid)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    raw = QUIET;
    if      (avg >= bus.th3) raw = VERY_LOUD;
    else if (avg >= bus.th2) raw = LOUD;
    else if (avg >= bus.th1) raw = MODERATE;

    case (level_q)
      MODERATE:  th_cur = bus.th1;
      LOUD:      th_cur = bus.th2;
      VERY_LOUD: th_cur = bus.th3;
      default:   th_cur = '0;
    endcase

    // Falling only once the average clears the current threshold by HYST.
    level_d = level_q;
    if (raw >= level_q || avg < sat_sub(th_cur, LOUDNESS_W'(HYST))) level_d = raw;

    count_d = '0;
    if (level_d == VERY_LOUD) count_d = (count_q == HOLD_C) ? count_q : count_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q       <= QUIET;
      count_q       <= '0;
      alarm_q       <= 1'b0;
      level_valid_q <= 1'b0;
    end else begin
      level_valid_q <= avg_valid;
      if (avg_valid) begin
        level_q <= level_d;
        count_q <= count_d;
        alarm_q <= (count_d == HOLD_C);
      end
    end
  end

  assign bus.avg_loudness = avg;
  assign bus.level        = level_q;
  assign bus.level_valid  = level_valid_q;
  assign bus.alarm        = alarm_q;

endmodule

// File: tb/tb_loudness_level_tracker.sv
// Directed bench for loudness_level_tracker: a queue-based moving-average and
// level model predicts every output, with hand-computed literals on key updates.
module tb_loudness_level_tracker;
  import loudness_pkg::*;

  localparam int          LW   = LOUDNESS_W;
  localparam logic [63:0] HYST = 64'd4096;
  localparam int          HOLD = 3;
  localparam logic [63:0] ALL1 = 64'h0000_07FF_FFFF_FFFF;

  typedef struct {
    int          due;
    logic [63:0] avg;
    int          lvl;
    bit          alarm;
    bit          lit;
    logic [63:0] l_avg;
    int          l_lvl;
    bit          l_alarm;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  exp_t        pend[$];
  logic [63:0] hist[$];
  logic [63:0] th [1:3];
  int          m_level;
  int          m_count;
  logic [63:0] hold_avg;
  int          hold_level;
  bit          hold_alarm;

  loudness_level_tracker_if #(.LW(LW)) bus();

  loudness_level_tracker dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic model_reset();
    hist.delete();
    pend.delete();
    m_level    = 0;
    m_count    = 0;
    hold_avg   = '0;
    hold_level = 0;
    hold_alarm = 1'b0;
  endtask

  task automatic set_th(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    th[1] = a; th[2] = b; th[3] = c;
    bus.th1 = a[LW-1:0];
    bus.th2 = b[LW-1:0];
    bus.th3 = c[LW-1:0];
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    idle(2);
    rst_n = 1'b1;
    tick();
  endtask

  // Drive one loudness pulse for a single cycle and predict its update.
  task automatic pulse(input logic [63:0] v, input bit lit = 1'b0,
                       input logic [63:0] l_avg = '0, input int l_lvl = 0,
                       input bit l_alarm = 1'b0);
    exp_t        e;
    logic [63:0] sum;
    logic [63:0] avg;
    logic [63:0] lim;
    int          raw;
    bus.loudness       = v[LW-1:0];
    bus.loudness_valid = 1'b1;
    hist.push_back(v);
    if (hist.size() > 4) void'(hist.pop_front());
    sum = '0;
    foreach (hist[i]) sum += hist[i];
    avg = sum / 4;
    raw = 0;
    for (int k = 1; k <= 3; k++) if (avg >= th[k]) raw = k;
    if (raw >= m_level) m_level = raw;
    else begin
      lim = (th[m_level] > HYST) ? th[m_level] - HYST : 64'd0;
      if (avg < lim) m_level = raw;
    end
    m_count   = (m_level == 3) ? ((m_count < HOLD) ? m_count + 1 : HOLD) : 0;
    e.due     = cyc + 2;
    e.avg     = avg;
    e.lvl     = m_level;
    e.alarm   = (m_count == HOLD);
    e.lit     = lit;
    e.l_avg   = l_avg;
    e.l_lvl   = l_lvl;
    e.l_alarm = l_alarm;
    pend.push_back(e);
    tick();
    bus.loudness_valid = 1'b0;
  endtask

  // Every cycle: avg, level and alarm must hold their last predicted value,
  // level_valid must pulse exactly when an update is due.
  always @(negedge clk) begin
    int hit;
    hit = -1;
    for (int i = 0; i < pend.size(); i++) begin
      if (pend[i].due == cyc) hit = i;
      if (pend[i].due == cyc + 1) begin
        hold_avg = pend[i].avg;
        if (pend[i].lit) check("avg_literal", 64'(bus.avg_loudness), pend[i].l_avg);
      end
    end
    check("avg_loudness", 64'(bus.avg_loudness), hold_avg);
    check("level_valid", 64'(bus.level_valid), 64'(hit >= 0));
    if (hit >= 0) begin
      hold_level = pend[hit].lvl;
      hold_alarm = pend[hit].alarm;
      if (pend[hit].lit) begin
        check("level_literal", 64'(bus.level), 64'(pend[hit].l_lvl));
        check("alarm_literal", 64'(bus.alarm), 64'(pend[hit].l_alarm));
      end
      pend.delete(hit);
    end
    check("level", 64'(bus.level), 64'(hold_level));
    check("alarm", 64'(bus.alarm), 64'(hold_alarm));
  end

  initial begin
    bus.loudness       = '0;
    bus.loudness_valid = 1'b0;
    set_th(64'd5000, 64'd20000, 64'd40000);
    model_reset();
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    tick();

    check("reset_avg",         64'(bus.avg_loudness), 64'd0);
    check("reset_level",       64'(bus.level),        64'd0);
    check("reset_level_valid", 64'(bus.level_valid),  64'd0);
    check("reset_alarm",       64'(bus.alarm),        64'd0);
    idle(3);

    // Ramp: zero-filled buffer makes the average climb over four windows.
    pulse(64'd10000, 1'b1, 64'd2500,  0, 1'b0); idle(3);
    pulse(64'd10000, 1'b1, 64'd5000,  1, 1'b0); idle(3);
    pulse(64'd10000, 1'b1, 64'd7500,  1, 1'b0); idle(3);
    pulse(64'd10000, 1'b1, 64'd10000, 1, 1'b0); idle(3);

    // Hysteresis: level 1 holds until avg drops below 5000-4096 = 904.
    repeat (3) begin pulse(64'd6000); idle(2); end
    pulse(64'd6000, 1'b1, 64'd6000, 1, 1'b0); idle(2);
    repeat (3) begin pulse(64'd4000); idle(2); end
    pulse(64'd4000, 1'b1, 64'd4000, 1, 1'b0); idle(2);
    pulse(64'd800, 1'b1, 64'd3200, 1, 1'b0); idle(2);
    pulse(64'd800, 1'b1, 64'd2400, 1, 1'b0); idle(2);
    pulse(64'd800, 1'b1, 64'd1600, 1, 1'b0); idle(2);
    pulse(64'd800, 1'b1, 64'd800,  0, 1'b0); idle(3);

    // Jump and alarm.
    do_reset();
    pulse(64'd60000, 1'b1, 64'd15000, 1, 1'b0); idle(2);
    pulse(64'd60000, 1'b1, 64'd30000, 2, 1'b0); idle(2);
    pulse(64'd60000, 1'b1, 64'd45000, 3, 1'b0); idle(2);
    pulse(64'd60000, 1'b1, 64'd60000, 3, 1'b0); idle(2);
    pulse(64'd60000, 1'b1, 64'd60000, 3, 1'b1); idle(2);
    pulse(64'd60000, 1'b1, 64'd60000, 3, 1'b1); idle(2);
    pulse(64'd0,     1'b1, 64'd45000, 3, 1'b1); idle(2);
    pulse(64'd0,     1'b1, 64'd30000, 2, 1'b0); idle(3);

    // Misordered thresholds: highest k with avg >= th_k wins.
    do_reset();
    set_th(64'd30000, 64'd10000, 64'd20000);
    pulse(64'd60000, 1'b1, 64'd15000, 2, 1'b0); idle(3);
    do_reset();
    set_th(64'd5000, 64'd20000, 64'd40000);

    // Back-to-back pulses.
    pulse(64'd1000, 1'b1, 64'd250,  0, 1'b0);
    pulse(64'd2000, 1'b1, 64'd750,  0, 1'b0);
    pulse(64'd3000, 1'b1, 64'd1500, 0, 1'b0);
    idle(4);

    // Reset one cycle after a pulse discards it and clears the buffer.
    do_reset();
    pulse(64'd20000);
    rst_n = 1'b0;
    model_reset();
    idle(2);
    rst_n = 1'b1;
    idle(3);
    pulse(64'd8000, 1'b1, 64'd2000, 0, 1'b0); idle(4);

    // Width extremes: all-ones must not wrap the running sum.
    do_reset();
    repeat (3) begin pulse(ALL1); idle(1); end
    pulse(ALL1, 1'b1, ALL1, 3, 1'b1); idle(1);
    repeat (3) begin pulse(64'd0); idle(1); end
    pulse(64'd0, 1'b1, 64'd0, 0, 1'b0);
    idle(5);

    check("pending_drained", 64'(pend.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
